// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, state encoding and helpers.
// Imported by the arbiter and its address generator.
package fb_pkg;

  localparam int PX_WIDTH   = 160;
  localparam int PX_HEIGHT  = 120;
  localparam int PIX_W      = 3;
  localparam int ADDR_W     = 16;
  localparam int FRAME_SIZE = PX_WIDTH * PX_HEIGHT;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_t;

  function automatic logic is_last_px(
    input logic [ADDR_W-1:0] a
  );
    return a == ADDR_W'(FRAME_SIZE - 1);
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Pixel coordinate to linear address, plus range check.
// Ports: i_x, i_y (8b coords) -> o_addr (ADDR_W), o_in_range.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [7:0]        i_x,
  input  logic [7:0]        i_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_range
);

  logic [ADDR_W-1:0] w_x;
  logic [ADDR_W-1:0] w_y;

  assign w_x = ADDR_W'(i_x);
  assign w_y = ADDR_W'(i_y);

  assign o_addr = w_y * ADDR_W'(PX_WIDTH) + w_x;

  assign o_in_range = (w_x < ADDR_W'(PX_WIDTH)) &&
                      (w_y < ADDR_W'(PX_HEIGHT));

endmodule

// File: rtl/fb_arbiter.sv
// Single-port framebuffer arbiter: display reads, renderer
// writes and a full-frame clear engine, one access per cycle.
// Ports: clk/rst; disp_* read port (gnt, 2-cycle rvalid/rdata);
// rend_* write port; clr_start/busy/done; registered mem_* bus.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter logic [PIX_W-1:0] CLR_COLOR    = '0,
  parameter int               STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [7:0]        disp_x,
  input  logic [7:0]        disp_y,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [PIX_W-1:0]  disp_rdata,
  input  logic              rend_req,
  input  logic [7:0]        rend_x,
  input  logic [7:0]        rend_y,
  input  logic [PIX_W-1:0]  rend_color,
  output logic              rend_gnt,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [PIX_W-1:0]  mem_din,
  input  logic [PIX_W-1:0]  mem_dout
);

  localparam int SC_W =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  fb_state_t         r_state;
  fb_state_t         w_state_nxt;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [SC_W-1:0]   r_starve;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [PIX_W-1:0]  r_din;
  logic              r_done;
  logic [1:0]        r_rv;
  logic [1:0]        r_rng;

  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_disp_in;
  logic [ADDR_W-1:0] w_rend_addr;
  logic              w_rend_in;

  logic              w_busy;
  logic              w_force;
  logic              w_disp_gnt;
  logic              w_rend_gnt;
  logic              w_clr_gnt;
  logic              w_clr_last;

  fb_addr_gen u_disp_ag (
    .i_x        (disp_x),
    .i_y        (disp_y),
    .o_addr     (w_disp_addr),
    .o_in_range (w_disp_in)
  );

  fb_addr_gen u_rend_ag (
    .i_x        (rend_x),
    .i_y        (rend_y),
    .o_addr     (w_rend_addr),
    .o_in_range (w_rend_in)
  );

  assign w_busy  = (r_state == ST_CLEAR);
  assign w_force = rend_req && !w_busy &&
                   (r_starve == SC_MAX);

  // Grant selection; renderer is locked out during CLEAR.
  always_comb begin
    w_state_nxt = r_state;
    w_disp_gnt  = 1'b0;
    w_rend_gnt  = 1'b0;
    w_clr_gnt   = 1'b0;
    w_clr_last  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_force) begin
          w_rend_gnt = 1'b1;
        end else if (disp_req) begin
          w_disp_gnt = 1'b1;
        end else if (rend_req) begin
          w_rend_gnt = 1'b1;
        end
        if (clr_start) begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (disp_req) begin
          w_disp_gnt = 1'b1;
        end else begin
          w_clr_gnt = 1'b1;
          if (is_last_px(r_clr_cnt)) begin
            w_clr_last  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clr_cnt <= '0;
    end else if (!w_busy && clr_start) begin
      r_clr_cnt <= '0;
    end else if (w_clr_gnt) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
    end
  end

  // Counts display wins over a waiting renderer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_rend_gnt || w_busy) begin
      r_starve <= '0;
    end else if (rend_req && w_disp_gnt &&
                 (r_starve != SC_MAX)) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Memory bus; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_disp_gnt) begin
        r_addr <= w_disp_addr;
      end else if (w_clr_gnt) begin
        r_we   <= 1'b1;
        r_addr <= r_clr_cnt;
        r_din  <= CLR_COLOR;
      end else if (w_rend_gnt) begin
        r_we   <= w_rend_in;
        r_addr <= w_rend_addr;
        r_din  <= rend_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 1'b0;
      r_rv   <= '0;
      r_rng  <= '0;
    end else begin
      r_done <= w_clr_last;
      r_rv   <= {r_rv[0], w_disp_gnt};
      r_rng  <= {r_rng[0], w_disp_gnt & w_disp_in};
    end
  end

  assign disp_gnt    = w_disp_gnt;
  assign rend_gnt    = w_rend_gnt;
  assign clr_busy    = w_busy;
  assign clr_done    = r_done;
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_din     = r_din;
  assign disp_rvalid = r_rv[1];
  assign disp_rdata  = (r_rv[1] && r_rng[1]) ? mem_dout : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a 1-cycle memory model.
// Read expectations are queued at grant, checked at rvalid.
module tb_fb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [7:0]  disp_x = '0;
  logic [7:0]  disp_y = '0;
  logic        disp_gnt;
  logic        disp_rvalid;
  logic [2:0]  disp_rdata;
  logic        rend_req = 1'b0;
  logic [7:0]  rend_x = '0;
  logic [7:0]  rend_y = '0;
  logic [2:0]  rend_color = '0;
  logic        rend_gnt;
  logic        clr_start = 1'b0;
  logic        clr_busy;
  logic        clr_done;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [2:0]  mem_din;
  logic [2:0]  mem_dout;

  logic        poke_en = 1'b0;
  logic [15:0] poke_a = '0;
  logic [2:0]  poke_d = '0;
  logic [2:0]  mem [0:65535];

  typedef struct {
    int         due;
    logic [2:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  fb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .disp_req    (disp_req),
    .disp_x      (disp_x),
    .disp_y      (disp_y),
    .disp_gnt    (disp_gnt),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .rend_req    (rend_req),
    .rend_x      (rend_x),
    .rend_y      (rend_y),
    .rend_color  (rend_color),
    .rend_gnt    (rend_gnt),
    .clr_start   (clr_start),
    .clr_busy    (clr_busy),
    .clr_done    (clr_done),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_a] <= poke_d;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
    mem_dout <= mem[mem_addr];
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (disp_rvalid === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL rvalid_unexpected cyc=%0d rdata=%0d",
                 cyc, disp_rdata);
      end else begin
        mon_e = sbq.pop_front();
        if (mon_e.due != cyc || disp_rdata !== mon_e.data) begin
          errors++;
          $display("FAIL rdata cyc=%0d got=%0d exp_cyc=%0d exp=%0d",
                   cyc, disp_rdata, mon_e.due, mon_e.data);
        end
      end
    end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
      checks++;
      errors++;
      mon_e = sbq.pop_front();
      $display("FAIL rvalid_missing cyc=%0d exp_cyc=%0d",
               cyc, mon_e.due);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    poke_en = 1'b1;
    poke_a = 16'd325;
    poke_d = 3'b101;
    tick();
    poke_a = 16'd0;
    poke_d = 3'b110;
    tick();
    poke_en = 1'b0;
    tick();
    checks++;
    if ({mem_we, mem_addr, mem_din, disp_rvalid, disp_rdata,
         clr_busy, clr_done, disp_gnt, rend_gnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs we=%b addr=%0d din=%0d rv=%b busy=%b done=%b exp=all0",
               mem_we, mem_addr, mem_din, disp_rvalid,
               clr_busy, clr_done);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read();
    disp_req = 1'b1;
    disp_x = 8'd5;
    disp_y = 8'd2;
    #1;
    checks++;
    if (disp_gnt !== 1'b1 || rend_gnt !== 1'b0) begin
      errors++;
      $display("FAIL read_gnt got=%b%b exp=10", disp_gnt, rend_gnt);
    end
    sbq.push_back('{cyc + 2, 3'b101});
    tick();
    disp_req = 1'b0;
    checks++;
    if (mem_addr !== 16'd325 || mem_we !== 1'b0 ||
        disp_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_addr got=%0d we=%b rv=%b exp=325 0 0",
               mem_addr, mem_we, disp_rvalid);
    end
    tick();
    checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 3'b101) begin
      errors++;
      $display("FAIL read_data rv=%b got=%0d exp=1 5",
               disp_rvalid, disp_rdata);
    end
    disp_req = 1'b1;
    disp_x = 8'd0;
    disp_y = 8'd120;
    #1;
    checks++;
    if (disp_gnt !== 1'b1) begin
      errors++;
      $display("FAIL oob_read_gnt got=%b exp=1", disp_gnt);
    end
    sbq.push_back('{cyc + 2, 3'b000});
    tick();
    disp_req = 1'b0;
    tick();
    checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 3'b000) begin
      errors++;
      $display("FAIL oob_read rv=%b got=%0d exp=1 0",
               disp_rvalid, disp_rdata);
    end
    tick();
  endtask

  task automatic test_rend_write();
    rend_req = 1'b1;
    rend_x = 8'd159;
    rend_y = 8'd119;
    rend_color = 3'b011;
    #1;
    checks++;
    if (rend_gnt !== 1'b1 || disp_gnt !== 1'b0) begin
      errors++;
      $display("FAIL wr_gnt got=%b%b exp=10", rend_gnt, disp_gnt);
    end
    tick();
    rend_req = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd19199 ||
        mem_din !== 3'b011) begin
      errors++;
      $display("FAIL wr_bus we=%b addr=%0d din=%0d exp=1 19199 3",
               mem_we, mem_addr, mem_din);
    end
    tick();
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 16'd19199 ||
        mem_din !== 3'b011) begin
      errors++;
      $display("FAIL idle_hold we=%b addr=%0d din=%0d exp=0 19199 3",
               mem_we, mem_addr, mem_din);
    end
    rend_req = 1'b1;
    rend_x = 8'd160;
    rend_y = 8'd0;
    #1;
    checks++;
    if (rend_gnt !== 1'b1) begin
      errors++;
      $display("FAIL oob_wr_gnt got=%b exp=1", rend_gnt);
    end
    tick();
    rend_req = 1'b0;
    checks++;
    if (mem_we !== 1'b0) begin
      errors++;
      $display("FAIL oob_wr_we got=%b exp=0", mem_we);
    end
    tick();
  endtask

  task automatic test_starve();
    logic exp_r;
    disp_req = 1'b1;
    disp_x = 8'd5;
    disp_y = 8'd2;
    rend_req = 1'b1;
    rend_x = 8'd1;
    rend_y = 8'd1;
    rend_color = 3'b010;
    for (int i = 0; i < 25; i++) begin
      #1;
      exp_r = ((i % 5) == 4);
      checks++;
      if (rend_gnt !== exp_r || disp_gnt !== !exp_r) begin
        errors++;
        $display("FAIL starve_gnt i=%0d rend=%b disp=%b exp_rend=%b",
                 i, rend_gnt, disp_gnt, exp_r);
      end
      if (!exp_r) sbq.push_back('{cyc + 2, 3'b101});
      tick();
    end
    disp_req = 1'b0;
    rend_req = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_clear();
    int bad_ctl = 0;
    int bad_wr = 0;
    int first_bad = -1;
    rend_req = 1'b1;
    rend_x = 8'd10;
    rend_y = 8'd0;
    rend_color = 3'b111;
    clr_start = 1'b1;
    #1;
    checks++;
    if (rend_gnt !== 1'b1) begin
      errors++;
      $display("FAIL clr_start_rend_gnt got=%b exp=1", rend_gnt);
    end
    tick();
    clr_start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd10 ||
        mem_din !== 3'b111 || clr_busy !== 1'b1) begin
      errors++;
      $display("FAIL clr_pre_wr we=%b addr=%0d din=%0d busy=%b exp=1 10 7 1",
               mem_we, mem_addr, mem_din, clr_busy);
    end
    for (int k = 0; k < 19200; k++) begin
      if (clr_busy !== 1'b1 || clr_done !== 1'b0 ||
          rend_gnt !== 1'b0) bad_ctl++;
      tick();
      if (mem_we !== 1'b1 || mem_addr !== 16'(k) ||
          mem_din !== 3'b000) begin
        if (first_bad < 0) first_bad = k;
        bad_wr++;
      end
    end
    checks++;
    if (bad_ctl != 0) begin
      errors++;
      $display("FAIL clr_ctl bad_cycles=%0d exp=0", bad_ctl);
    end
    checks++;
    if (bad_wr != 0) begin
      errors++;
      $display("FAIL clr_writes bad=%0d first_k=%0d exp=0",
               bad_wr, first_bad);
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b1 ||
        rend_gnt !== 1'b1) begin
      errors++;
      $display("FAIL clr_end busy=%b done=%b rgnt=%b exp=0 1 1",
               clr_busy, clr_done, rend_gnt);
    end
    rend_req = 1'b0;
    tick();
    checks++;
    if (clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_pulse got=%b exp=0", clr_done);
    end
    tick();
  endtask

  task automatic test_clear_disp();
    int bad_ctl = 0;
    int bad_wr = 0;
    int nwr = 0;
    poke_en = 1'b1;
    poke_a = 16'd0;
    poke_d = 3'b110;
    tick();
    poke_en = 1'b0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    disp_x = 8'd0;
    disp_y = 8'd0;
    for (int k = 0; k < 38400; k++) begin
      disp_req = ((k % 2) == 0);
      #1;
      if (disp_gnt !== disp_req || clr_busy !== 1'b1 ||
          clr_done !== 1'b0) bad_ctl++;
      if (disp_req)
        sbq.push_back('{cyc + 2, (k == 0) ? 3'b110 : 3'b000});
      tick();
      if (mem_we === 1'b1) begin
        if (mem_addr !== 16'(nwr)) bad_wr++;
        nwr++;
      end
    end
    disp_req = 1'b0;
    checks++;
    if (bad_ctl != 0 || bad_wr != 0) begin
      errors++;
      $display("FAIL clrd_seq bad_ctl=%0d bad_wr=%0d exp=0 0",
               bad_ctl, bad_wr);
    end
    checks++;
    if (nwr != 19200 || mem_addr !== 16'd19199) begin
      errors++;
      $display("FAIL clrd_count writes=%0d last=%0d exp=19200 19199",
               nwr, mem_addr);
    end
    checks++;
    if (clr_busy !== 1'b0 || clr_done !== 1'b1) begin
      errors++;
      $display("FAIL clrd_end busy=%b done=%b exp=0 1",
               clr_busy, clr_done);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_clear();
    int bad_done = 0;
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    for (int k = 0; k < 1000; k++) tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd999) begin
      errors++;
      $display("FAIL rc_pre we=%b addr=%0d exp=1 999",
               mem_we, mem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({mem_we, mem_addr, mem_din, disp_rvalid, disp_rdata,
         clr_busy, clr_done, disp_gnt, rend_gnt} !== '0) begin
      errors++;
      $display("FAIL rc_reset we=%b addr=%0d busy=%b done=%b exp=all0",
               mem_we, mem_addr, clr_busy, clr_done);
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (clr_done !== 1'b0 || clr_busy !== 1'b0) bad_done++;
    end
    checks++;
    if (bad_done != 0) begin
      errors++;
      $display("FAIL rc_no_done bad=%0d exp=0", bad_done);
    end
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd0) begin
      errors++;
      $display("FAIL rc_restart we=%b addr=%0d exp=1 0",
               mem_we, mem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_rend_write();
    test_starve();
    test_clear();
    test_clear_disp();
    test_reset_clear();
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
